// File: rtl/axi_lite_inst_sram_rd_slave.sv
// AXI4-Lite read-only responder (AR + R) serving instruction fetches from a
// word-addressed SRAM image, with fixed response latency, SLVERR/DECERR
// decode and a synchronous preload port.
module axi_lite_inst_sram_rd_slave #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned             DEPTH      = 1024,
    parameter int unsigned             LATENCY    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      ar_addr_i,
    input  logic                       ar_valid_i,
    output logic                       ar_ready_o,
    output logic [DATA_WIDTH-1:0]      r_data_o,
    output logic [1:0]                 r_resp_o,
    output logic                       r_valid_o,
    input  logic                       r_ready_i,
    input  logic                       load_en_i,
    input  logic [$clog2(DEPTH)-1:0]   load_idx_i,
    input  logic [DATA_WIDTH-1:0]      load_data_i
);

    localparam int unsigned           IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);
    localparam logic [3:0]            LAT4  = 4'(LATENCY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
    logic [1:0]              r_resp_q, r_resp_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic [ADDR_WIDTH-1:0]   dec_offset;
    logic [DATA_WIDTH-1:0]   dec_data;
    logic [1:0]              dec_resp;

    // Preload port: memory is never reset so the image survives reset.
    always_ff @(posedge clock) begin
        if (load_en_i) begin
            mem[load_idx_i] <= load_data_i;
        end
    end

    // Decode the live AR address in IDLE (zero-latency case captures it on the
    // handshake edge) and the latched address otherwise.
    always_comb begin
        dec_addr   = (state_q == S_IDLE) ? ar_addr_i : addr_q;
        dec_offset = dec_addr - BASE_ADDR;
        dec_data   = '0;
        dec_resp   = RESP_OKAY;
        if (dec_addr[1:0] != 2'b00) begin
            dec_resp = RESP_SLVERR;
        end else if ((dec_addr < BASE_ADDR) || (dec_offset >= SPAN)) begin
            dec_resp = RESP_DECERR;
        end else begin
            dec_data = mem[dec_offset[IDX_W+1:2]];
        end
    end

    // Next-state and output logic for the single-outstanding read FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        ar_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ar_ready_o = !reset;
                if (ar_valid_i) begin
                    addr_d = ar_addr_i;
                    cnt_d  = LAT4;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d  = S_RESP;
                        r_data_d = dec_data;
                        r_resp_d = dec_resp;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = S_RESP;
                    r_data_d = dec_data;
                    r_resp_d = dec_resp;
                end
            end
            S_RESP: begin
                if (r_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and response registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            r_data_q <= '0;
            r_resp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
        end
    end

    assign r_valid_o = (state_q == S_RESP);
    assign r_data_o  = r_data_q;
    assign r_resp_o  = r_resp_q;

endmodule

// File: tb/tb_axi_lite_inst_sram_rd_slave.sv
// Bench for axi_lite_inst_sram_rd_slave: three instances (LATENCY 0, 2, 7)
// share address/load/reset and are checked against a behavioural memory model.
module tb_axi_lite_inst_sram_rd_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ar_addr;
    logic        ar_valid [3];
    logic        ar_ready [3];
    logic [31:0] r_data   [3];
    logic [1:0]  r_resp   [3];
    logic        r_valid  [3];
    logic        r_ready  [3];
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    int          lats [3] = '{0, 2, 7};
    logic [31:0] mem_m [DEPTH];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    always #5 clock = ~clock;

    axi_lite_inst_sram_rd_slave #(.LATENCY(0)) u_dut0 (
        .clock(clock), .reset(reset), .ar_addr_i(ar_addr), .ar_valid_i(ar_valid[0]),
        .ar_ready_o(ar_ready[0]), .r_data_o(r_data[0]), .r_resp_o(r_resp[0]),
        .r_valid_o(r_valid[0]), .r_ready_i(r_ready[0]), .load_en_i(load_en),
        .load_idx_i(load_idx), .load_data_i(load_data));

    axi_lite_inst_sram_rd_slave #(.LATENCY(2)) u_dut1 (
        .clock(clock), .reset(reset), .ar_addr_i(ar_addr), .ar_valid_i(ar_valid[1]),
        .ar_ready_o(ar_ready[1]), .r_data_o(r_data[1]), .r_resp_o(r_resp[1]),
        .r_valid_o(r_valid[1]), .r_ready_i(r_ready[1]), .load_en_i(load_en),
        .load_idx_i(load_idx), .load_data_i(load_data));

    axi_lite_inst_sram_rd_slave #(.LATENCY(7)) u_dut2 (
        .clock(clock), .reset(reset), .ar_addr_i(ar_addr), .ar_valid_i(ar_valid[2]),
        .ar_ready_o(ar_ready[2]), .r_data_o(r_data[2]), .r_resp_o(r_resp[2]),
        .r_valid_o(r_valid[2]), .r_ready_i(r_ready[2]), .load_en_i(load_en),
        .load_idx_i(load_idx), .load_data_i(load_data));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference decode: {resp, data} from plain address arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a);
        longint unsigned la = a;
        if (a % 4 != 0) return {2'b10, 32'h0};
        if (la < BASE || la >= longint'(BASE) + 4 * DEPTH) return {2'b11, 32'h0};
        return {2'b00, mem_m[int'((la - BASE) / 4)]};
    endfunction

    task automatic load_word(input int idx, input logic [31:0] d);
        @(negedge clock);
        load_en   = 1'b1;
        load_idx  = 10'(idx);
        load_data = d;
        mem_m[idx] = d;
        @(posedge clock);
        #1 load_en = 1'b0;
    endtask

    // One full read on instance k: timing of first R beat, stability under
    // backpressure for bp cycles, and return to IDLE after the R handshake.
    task automatic fetch(input int k, input logic [31:0] addr, input int bp);
        int          lat = lats[k];
        logic [33:0] exp = model(addr);
        @(negedge clock);
        ar_addr     = addr;
        ar_valid[k] = 1'b1;
        r_ready[k]  = 1'b0;
        check_eq("ar_ready_idle", 32'(ar_ready[k]), 32'd1);
        @(posedge clock);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clock);
            ar_valid[k] = 1'($urandom_range(0, 1));
            ar_addr     = $urandom;
            check_eq("r_valid_timing", 32'(r_valid[k]), 32'(c == lat + 1));
            check_eq("ar_ready_busy", 32'(ar_ready[k]), 32'd0);
        end
        check_eq("r_data", r_data[k], exp[31:0]);
        check_eq("r_resp", 32'(r_resp[k]), 32'(exp[33:32]));
        for (int b = 0; b < bp; b++) begin
            @(negedge clock);
            ar_valid[k] = 1'($urandom_range(0, 1));
            check_eq("bp_valid", 32'(r_valid[k]), 32'd1);
            check_eq("bp_data", r_data[k], exp[31:0]);
            check_eq("bp_resp", 32'(r_resp[k]), 32'(exp[33:32]));
            check_eq("bp_ar_ready", 32'(ar_ready[k]), 32'd0);
        end
        r_ready[k]  = 1'b1;
        ar_valid[k] = 1'b0;
        @(negedge clock);
        check_eq("r_valid_drop", 32'(r_valid[k]), 32'd0);
        check_eq("ar_ready_back", 32'(ar_ready[k]), 32'd1);
        r_ready[k] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            1:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            2:       return 32'($urandom_range(0, 32'h7FFF_FFFF)) & ~32'h3;
            default: return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1 << 20));
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        ar_addr   = '0;
        load_en   = 1'b0;
        load_idx  = '0;
        load_data = '0;
        for (int k = 0; k < 3; k++) begin
            ar_valid[k] = 1'b0;
            r_ready[k]  = 1'b0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_r_valid", 32'(r_valid[k]), 32'd0);
            check_eq("rst_r_data", r_data[k], 32'd0);
            check_eq("rst_r_resp", 32'(r_resp[k]), 32'd0);
            check_eq("rst_ar_ready", 32'(ar_ready[k]), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
        load_word(0, 32'h0000_0413);
        load_word(1, 32'hDEAD_BEEF);

        // Directed fetches on the LATENCY=2 instance.
        fetch(1, 32'h8000_0000, 0);
        fetch(1, 32'h8000_0004, 5);
        fetch(1, 32'h8000_0002, 0);
        fetch(1, 32'h7FFF_FFFC, 0);
        fetch(1, 32'h8000_1000, 2);
        fetch(1, 32'h8000_0FFC, 0);
        // Latency sweep, back-to-back.
        fetch(0, 32'h8000_0000, 0);
        fetch(0, 32'h8000_0004, 0);
        fetch(0, 32'h8000_0003, 1);
        fetch(2, 32'h8000_0004, 0);
        fetch(2, 32'h8000_0FFC, 3);

        // Load race: T+1 load visible, load on the RESP-entry edge is not.
        load_word(3, 32'h1111_1111);
        @(negedge clock);
        ar_addr     = BASE + 32'hC;
        ar_valid[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ar_valid[1] = 1'b0;
        load_en = 1'b1; load_idx = 10'd3; load_data = 32'h2222_2222;
        @(negedge clock);
        load_data = 32'h3333_3333;
        @(negedge clock);
        load_en = 1'b0;
        mem_m[3] = 32'h3333_3333;
        check_eq("race_valid", 32'(r_valid[1]), 32'd1);
        check_eq("race_data", r_data[1], 32'h2222_2222);
        r_ready[1] = 1'b1;
        @(negedge clock);
        r_ready[1] = 1'b0;
        check_eq("race_done", 32'(r_valid[1]), 32'd0);
        fetch(1, BASE + 32'hC, 0);

        // Reset in the middle of a pending read; load accepted during reset.
        @(negedge clock);
        ar_addr     = BASE + 32'h8;
        ar_valid[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ar_valid[1] = 1'b0;
        r_ready[1]  = 1'b1;
        reset       = 1'b1;
        load_en = 1'b1; load_idx = 10'd5; load_data = 32'h5555_AAAA;
        mem_m[5] = 32'h5555_AAAA;
        repeat (2) begin
            @(negedge clock);
            load_en = 1'b0;
            check_eq("mrst_r_valid", 32'(r_valid[1]), 32'd0);
            check_eq("mrst_ar_ready", 32'(ar_ready[1]), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_eq("post_rst_valid", 32'(r_valid[1]), 32'd0);
            check_eq("post_rst_ar_ready", 32'(ar_ready[1]), 32'd1);
        end
        r_ready[1] = 1'b0;
        fetch(1, BASE + 32'h8, 0);
        fetch(1, BASE + 32'h14, 1);

        // Randomized fetches across all three latencies.
        for (int n = 0; n < 60; n++) begin
            fetch(int'($urandom_range(0, 2)), rand_addr(), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_lite_inst_sram_rd_slave.md
Name: axi_lite_inst_sram_rd_slave

Overview:
- AXI4-Lite read-channel responder (AR + R only) that serves instruction fetches from the IFU's AXI read master, backed by a word-addressed on-chip SRAM model.
- Adds a fixed, parameterised response latency so fetch timing and handshake robustness can be exercised.
- Returns error responses for misaligned and out-of-range addresses.
- Provides a synchronous preload port so the bench or loader can fill the memory image.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width; word = DATA_WIDTH/8 bytes.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of words; power of two.
- LATENCY, 2, extra cycles between AR handshake and first R valid; legal 0..15.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ar_addr_i  in  ADDR_WIDTH  read byte address.
- ar_valid_i  in  1  master address valid.
- ar_ready_o  out  1  slave can accept an address.
- r_data_o  out  DATA_WIDTH  read data.
- r_resp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- r_valid_o  out  1  read data/response valid.
- r_ready_i  in  1  master accepts the response.
- load_en_i  in  1  preload write strobe.
- load_idx_i  in  log2(DEPTH)  preload word index.
- load_data_i  in  DATA_WIDTH  preload data.

Behaviour:
- Reset values: r_valid_o=0, r_data_o=0, r_resp_o=00, state=IDLE, latency counter=0. ar_ready_o is forced to 0 while reset is high. The memory array is NOT reset; its contents survive reset.
- One outstanding transaction; no pipelining. States: IDLE, WAIT, RESP.
- IDLE:
  - ar_ready_o=1 (when not in reset).
  - On ar_valid_i & ar_ready_o: latch the address, load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - ar_ready_o=0; counter decrements each cycle.
  - When counter==1, next state is RESP.
- Entry to RESP: r_data_o and r_resp_o are registered on the same edge that enters RESP. The first r_valid_o=1 cycle is exactly T+1+LATENCY, where T is the AR handshake cycle.
- RESP:
  - r_valid_o=1; r_data_o and r_resp_o stay stable until r_ready_i=1.
  - On the r_valid_o & r_ready_i edge: return to IDLE, r_valid_o=0.
  - ar_ready_o stays 0 throughout RESP, so the next AR handshake is earliest the cycle after R completes.
- Address decode, in priority order:
  - ar_addr[1:0]!=0: resp=10, data=0.
  - addr<BASE_ADDR or addr>=BASE_ADDR+DEPTH*4: resp=11, data=0.
  - otherwise: resp=00, data=mem[(addr-BASE_ADDR)>>2]. The subtraction is unsigned 32-bit; the index uses only the low log2(DEPTH) bits after the range check.
- Error responses complete through the normal R handshake; the slave never drops or hangs on them.
- Preload: when load_en_i=1, mem[load_idx_i]<=load_data_i on the rising edge. Loads are accepted in any state, including during reset.
  - A load to the target word on any edge before the RESP-entry edge is visible in r_data_o.
  - A load on the RESP-entry edge itself is not visible (old value returned).
  - Loads never modify r_data_o while in RESP.
- ar_valid_i outside IDLE is ignored; the address is not latched.
- r_ready_i outside RESP is ignored.
- Reset mid-WAIT or mid-RESP: the transaction is abandoned and state returns to IDLE. r_valid_o=0 on the first post-reset cycle; no stale response is delivered afterwards.

Test Plan:
- Preload idx 0 = 32'h0000_0413, then AR 32'h8000_0000 with r_ready_i held 1 (LATENCY=2):
  - ar_ready_o=1 at handshake cycle T.
  - r_valid_o first high at T+3 with data 32'h0000_0413, resp 00; r_valid_o drops at T+4.
- Backpressure: AR 32'h8000_0004 (idx 1 = 32'hDEAD_BEEF), r_ready_i low for 5 cycles after r_valid_o rises:
  - r_valid_o/data/resp stay constant for all 5 cycles; ar_ready_o=0 throughout.
  - Completes on the cycle r_ready_i rises.
- Errors:
  - AR 32'h8000_0002 → resp 10, data 0.
  - AR 32'h7FFF_FFFC → resp 11.
  - AR 32'h8000_1000 (DEPTH=1024) → resp 11.
  - AR 32'h8000_0FFC → resp 00, data = idx 1023.
- Latency sweep LATENCY=0 and 7: r_valid_o first high at T+1 and T+8 respectively; back-to-back fetches are never accepted during RESP.
- Load race (LATENCY=2): load idx 3=32'h1111_1111 before fetch; during WAIT, load idx 3=32'h2222_2222 at T+1 and 32'h3333_3333 at T+2:
  - Returned data is 32'h2222_2222 (the T+2 load coincides with the RESP-entry edge and is not visible).
- Reset asserted at T+1 of a pending read:
  - r_valid_o=0, ar_ready_o=0 during reset, ar_ready_o=1 after reset.
  - No R beat ever appears for the abandoned read.
  - A new AR to a preloaded word returns the preserved memory data.
